// File: rtl/multi_note_timer_pkg.sv
// Shared types and default sizing for the multi-voice note timer.
package multi_note_timer_pkg;

  localparam int NUM_VOICES_DEF = 4;
  localparam int LEN_W_DEF      = 6;

  typedef enum logic {
    VOICE_IDLE = 1'b0,
    VOICE_RUN  = 1'b1
  } voice_state_t;

endpackage

// File: rtl/multi_note_timer_voice.sv
// One note timer: a beat down-counter that ends or reloads at terminal count 1.
//   state      | meaning
//   VOICE_IDLE | no note playing, count held at 0
//   VOICE_RUN  | note in progress, count = beats left including the current one
module note_voice
  import multi_note_timer_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             beat,
  input  logic             play,
  input  logic             pause,
  input  logic             load,
  input  logic [LEN_W-1:0] length,
  input  logic             loop,
  output logic             note_did_end,
  output logic             active,
  output logic [LEN_W-1:0] remaining
);

  voice_state_t     state;
  logic [LEN_W-1:0] count;
  logic [LEN_W-1:0] reload;
  logic             loop_q;
  logic             advance;

  assign advance = play & ~pause & beat;

  // load wins over advance, so a restart never emits an end pulse for the aborted note
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= VOICE_IDLE;
      count        <= '0;
      reload       <= '0;
      loop_q       <= 1'b0;
      note_did_end <= 1'b0;
    end else begin
      note_did_end <= 1'b0;
      if (load) begin
        if (length != '0) begin
          state  <= VOICE_RUN;
          count  <= length;
          reload <= length;
          loop_q <= loop;
        end else begin
          state        <= VOICE_IDLE;
          count        <= '0;
          note_did_end <= 1'b1;
        end
      end else if (advance && state == VOICE_RUN) begin
        if (count > LEN_W'(1)) begin
          count <= count - LEN_W'(1);
        end else begin
          note_did_end <= 1'b1;
          if (loop_q) begin
            count <= reload;
          end else begin
            count <= '0;
            state <= VOICE_IDLE;
          end
        end
      end
    end
  end

  assign active    = (state == VOICE_RUN);
  assign remaining = count;

endmodule

// File: rtl/multi_note_timer.sv
// Bank of independent note timers sharing the beat/play/pause controls.
module multi_note_timer
  import multi_note_timer_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int LEN_W      = LEN_W_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        beat,
  input  logic                        play,
  input  logic                        pause,
  input  logic [NUM_VOICES-1:0]       load,
  input  logic [NUM_VOICES*LEN_W-1:0] note_length,
  input  logic [NUM_VOICES-1:0]       loop,
  output logic [NUM_VOICES-1:0]       note_did_end,
  output logic [NUM_VOICES-1:0]       active,
  output logic [NUM_VOICES*LEN_W-1:0] remaining,
  output logic                        all_idle
);

  for (genvar i = 0; i < NUM_VOICES; i++) begin : g_voice
    note_voice #(.LEN_W(LEN_W)) u_voice (
      .clk          (clk),
      .reset        (reset),
      .beat         (beat),
      .play         (play),
      .pause        (pause),
      .load         (load[i]),
      .length       (note_length[i*LEN_W +: LEN_W]),
      .loop         (loop[i]),
      .note_did_end (note_did_end[i]),
      .active       (active[i]),
      .remaining    (remaining[i*LEN_W +: LEN_W])
    );
  end

  assign all_idle = ~|active;

endmodule

// File: doc/multi_note_timer.md
MULTI_NOTE_TIMER -- requirements
Module: multi_note_timer

Interface
REQ-001 The block SHALL have parameter NUM_VOICES, default 4, giving the number of independent note timers (1..16).
REQ-002 The block SHALL have parameter LEN_W, default 6, giving the note-length width in beats (2..16).
REQ-003 The block SHALL have these ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- beat  in  1  one-cycle beat strobe; tie high to count clock cycles.
- play  in  1  global run enable.
- pause  in  1  global hold request.
- load  in  NUM_VOICES  per-voice start pulse.
- note_length  in  NUM_VOICES*LEN_W  per-voice length; voice i uses bits [i*LEN_W +: LEN_W].
- loop  in  NUM_VOICES  per-voice repeat mode, sampled on load.
- note_did_end  out  NUM_VOICES  per-voice one-cycle end pulse.
- active  out  NUM_VOICES  per-voice "note in progress" level.
- remaining  out  NUM_VOICES*LEN_W  per-voice live beat count.
- all_idle  out  1  high when no voice is active.

Function
REQ-004 Each voice SHALL run a two-state machine, IDLE and RUN, with registers count[LEN_W], reload[LEN_W] and loop_q.
REQ-005 Voice i SHALL advance only when advance = play & ~pause & beat.
- pause SHALL take priority over play.
- When not advancing, count and state SHALL hold.
REQ-006 When load[i]=1 with length L != 0, the voice SHALL do the following in the next cycle:
- count <= L, reload <= L, loop_q <= loop[i], state <= RUN.
- This SHALL apply in any state, and load SHALL take priority over advance in the same cycle.
REQ-007 When load[i]=1 with L = 0, the voice SHALL go to IDLE with count=0 and pulse note_did_end[i] in the next cycle.
REQ-008 In RUN with advance and count > 1, count SHALL decrement by 1.
REQ-009 In RUN with advance and count = 1, the voice SHALL pulse note_did_end[i] high in the next cycle. Then:
- If loop_q=1: count <= reload and the state stays RUN (no dead beat).
- If loop_q=0: count <= 0 and state <= IDLE.
REQ-010 A load that restarts a voice in RUN SHALL suppress any end pulse for the aborted note, even if that note's count was 1 with advance high.
REQ-011 note_did_end[i] SHALL be a registered pulse, exactly one cycle wide, per note completion.
REQ-012 active[i] SHALL equal (state==RUN); remaining[i] SHALL equal count.
REQ-013 all_idle SHALL be the combinational NOR of active.
REQ-014 In IDLE, advance SHALL have no effect and count SHALL never underflow below 0.
REQ-015 Voices SHALL be fully independent apart from the shared beat, play and pause inputs, and simultaneous loads and ends on different voices SHALL all be honoured in the same cycle.

Reset
REQ-016 Asserting reset low SHALL immediately force every voice to:
- IDLE, count=0, reload=0, loop_q=0
- note_did_end=0, active=0, all_idle=1
REQ-017 Deasserting reset SHALL begin normal operation at the first rising clk edge after deassertion.
REQ-018 Reset asserted mid-note SHALL discard the note without an end pulse.

Structure
REQ-019 Package multi_note_timer_pkg SHALL hold the voice-state enum (VOICE_IDLE, VOICE_RUN) and the default parameter constants.
REQ-020 Per-voice logic SHALL be a sub-module note_voice, instantiated NUM_VOICES times by a generate loop; the top SHALL contain only slicing and all_idle.
REQ-021 All state registers SHALL reset asynchronously on the active-low reset.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Single note: beat=1, play=1; load[0] with L=3 -> remaining 3,2,1; note_did_end[0] pulses exactly 3 cycles after load takes effect; active[0] falls in that same cycle.
- Pause: L=4 with pause high for 5 cycles mid-note -> count frozen during the pause; end pulse delayed by exactly 5 cycles; play=0 gives the same freeze.
- Loop: L=2, loop=1, run 10 beats -> end pulses every 2 beats; active stays 1 throughout; remaining sequence 2,1,2,1...
- Restart and zero length: reload L=5 while count=1 with advance high -> no end pulse, count=5; load L=0 -> single end pulse next cycle, active=0.
- Multi-voice and beat gating: voices 0..3 loaded with L=1,2,3,4 together, beat every 3rd cycle -> ends spaced 3 cycles apart; all_idle rises after voice 3 ends.
- Reset: assert reset at count=2 -> all outputs zero and all_idle=1 before the next clk edge; no pulse after release.
